// File: rtl/tdp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_pkg
// Description : Shared widths, RAM read latency, and the response entry type
//               for the TDP RAM port controller.
//               Optional macro TDP_RAM_CTRL_WACK_EN adds is_wr to the entry.
// Revision    : 1.0 - initial release
// ============================================================================
package tdp_ram_pkg;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 33;
  localparam int RAM_RD_LAT = 2;

  typedef struct packed {
`ifdef TDP_RAM_CTRL_WACK_EN
    logic              is_wr;
`endif
    logic [DATA_W-1:0] rdata;
  } rsp_entry_t;

  // Counts the operations still travelling through the RAM latency pipeline.
  function automatic int unsigned count_ones(input logic [RAM_RD_LAT-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < RAM_RD_LAT; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdp_ram_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_port_ctrl_if
// Description : Request/response streams and RAM port signals of one
//               controller. Macro TDP_RAM_CTRL_WACK_EN adds rsp_is_wr.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdp_ram_port_ctrl_if #(
  parameter int ADDR_W = tdp_ram_pkg::ADDR_W,
  parameter int DATA_W = tdp_ram_pkg::DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
`ifdef TDP_RAM_CTRL_WACK_EN
  logic              rsp_is_wr;
`endif
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
`ifdef TDP_RAM_CTRL_WACK_EN
    output rsp_is_wr,
`endif
    output req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din
  );

  // Agent plus RAM side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
`ifdef TDP_RAM_CTRL_WACK_EN
    input  rsp_is_wr,
`endif
    input  req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din
  );

endinterface
`default_nettype wire

// File: rtl/tdp_ram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_rsp_fifo
// Description : Synchronous FIFO of response entries; head reads as zero
//               while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_rsp_fifo #(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = logic
) (
  input  wire                         clk,
  input  wire                         rst_n,
  input  wire                         push,
  input  wire                         pop,
  input  ENTRY_T                      wr_data,
  output ENTRY_T                      rd_data,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        full,
  output logic                        empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ENTRY_T           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (!empty) rd_data = r_mem[r_rd_ptr];
  end

endmodule
`default_nettype wire

// File: rtl/tdp_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_port_ctrl
// Description : Credit-managed initiator for one port of the 512x33 TDP RAM;
//               hides the 2-cycle read latency behind a response FIFO.
//               Macro TDP_RAM_CTRL_WACK_EN makes writes return a response.
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_port_ctrl #(
  parameter int ADDR_W    = tdp_ram_pkg::ADDR_W,
  parameter int DATA_W    = tdp_ram_pkg::DATA_W,
  parameter int RSP_DEPTH = 4
) (
  input wire                 clk,
  input wire                 rst_n,
  tdp_ram_port_ctrl_if.slave bus
);

  import tdp_ram_pkg::*;

  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int USED_W = $clog2(RSP_DEPTH + RAM_RD_LAT + 1);

  logic                  w_accept;
  logic                  w_track;
  logic                  w_credit_ok;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [USED_W-1:0]     w_used;
  logic [RAM_RD_LAT-1:0] r_pipe;
  rsp_entry_t            w_push_entry;
  rsp_entry_t            w_head;

  // A same-cycle pop deliberately does not free a credit.
  assign w_used      = USED_W'(count_ones(r_pipe)) + USED_W'(w_fifo_count);
  assign w_credit_ok = (w_used < USED_W'(RSP_DEPTH));

  assign w_accept      = bus.req_valid & bus.req_ready;
  assign bus.ram_we    = w_accept & bus.req_we;
  assign bus.ram_addr  = bus.req_addr[ADDR_W-1:0];
  assign bus.ram_din   = bus.req_wdata[DATA_W-1:0];

`ifdef TDP_RAM_CTRL_WACK_EN
  logic [RAM_RD_LAT-1:0] r_pipe_wr;

  assign bus.req_ready = rst_n & w_credit_ok;
  assign w_track       = w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pipe_wr <= '0;
    else        r_pipe_wr <= {r_pipe_wr[RAM_RD_LAT-2:0], w_accept & bus.req_we};
  end

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.is_wr = r_pipe_wr[RAM_RD_LAT-1];
    w_push_entry.rdata = r_pipe_wr[RAM_RD_LAT-1] ? '0 : bus.ram_dout;
  end

  assign bus.rsp_is_wr = w_head.is_wr;
`else
  // Writes carry no response, so they never wait for a credit.
  assign bus.req_ready = rst_n & (bus.req_we | w_credit_ok);
  assign w_track       = w_accept & ~bus.req_we;

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.rdata = bus.ram_dout;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pipe <= '0;
    else        r_pipe <= {r_pipe[RAM_RD_LAT-2:0], w_track};
  end

  assign w_push        = r_pipe[RAM_RD_LAT-1];
  assign bus.rsp_valid = ~w_fifo_empty;
  assign w_pop         = bus.rsp_valid & bus.rsp_ready;
  assign bus.rsp_rdata = w_head.rdata;

  tdp_ram_rsp_fifo #(
    .DEPTH   (RSP_DEPTH),
    .ENTRY_T (rsp_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data (w_push_entry),
    .rd_data (w_head),
    .count   (w_fifo_count),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_tdp_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdp_ram_port_ctrl
// Description : Directed self-checking bench with a 2-cycle registered RAM
//               model and an in-order response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdp_ram_port_ctrl;

  import tdp_ram_pkg::*;

  typedef struct packed {
    logic              is_wr;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rsp_ready;
    logic              exp_req_ready;
    logic              exp_ram_we;
    logic              exp_rsp_valid;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdp_ram_port_ctrl_if bus ();

  tdp_ram_port_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RSP_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM model: registered read address, registered read data.
  logic [DATA_W-1:0] ram_mem [512];
  logic [ADDR_W-1:0] ram_addr_q;
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_din;
    ram_addr_q   <= bus.ram_addr;
    bus.ram_dout <= ram_mem[ram_addr_q];
  end

  logic [DATA_W-1:0] ref_mem [512];
  exp_t              exp_q [$];
  int                checks = 0;
  int                errors = 0;
  int                n_rsp  = 0;
  int                acc;
  int                base;
  int                first_c;
  int                last_c;
  vec_t              tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  // Inputs are set at the negedge; this scores the cycle and advances one clock.
  task automatic step();
    exp_t e;
    #2;
    chk("fifo_push_when_full", 64'(dut.w_push & dut.w_fifo_full), 64'd0);
    if (bus.req_valid && bus.req_ready) begin
      if (bus.req_we) begin
        ref_mem[bus.req_addr] = bus.req_wdata;
`ifdef TDP_RAM_CTRL_WACK_EN
        e.is_wr = 1'b1;
        e.data  = '0;
        exp_q.push_back(e);
`endif
      end else begin
        e.is_wr = 1'b0;
        e.data  = ref_mem[bus.req_addr];
        exp_q.push_back(e);
      end
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata 0x%0h required no response at %0t",
                 bus.rsp_rdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata_order", 64'(bus.rsp_rdata), 64'(e.data));
`ifdef TDP_RAM_CTRL_WACK_EN
        chk("rsp_is_wr_order", 64'(bus.rsp_is_wr), 64'(e.is_wr));
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = DATA_W'(i);
      ram_mem[i] = DATA_W'(i);
    end
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b1, 9'd7, 33'h1_FFFF_FFFF);

    // Reset state, including a write presented during reset.
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("reset_ram_we",    64'(bus.ram_we),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_mem_untouched", 64'(ram_mem[7]), 64'd7);
    step();

    // Back-to-back reads 0..15 with the consumer always ready.
    bus.rsp_ready = 1'b1;
    base    = n_rsp;
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) drive(1'b1, 1'b0, ADDR_W'(c), '0);
      else        drive(1'b0, 1'b0, '0, '0);
      #1;
      if (c < 16) chk("b2b_req_ready", 64'(bus.req_ready), 64'd1);
      if (bus.rsp_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      step();
    end
    chk("b2b_rsp_count",   64'(n_rsp - base),     64'd16);
    chk("b2b_first_cycle", 64'(first_c),          64'd3);
    chk("b2b_contiguous",  64'(last_c - first_c), 64'd15);

`ifndef TDP_RAM_CTRL_WACK_EN
    // Write then read the same address on consecutive cycles.
    tbl[0] = '{1'b1, 1'b1, 9'd5, 33'h1_2345_6789, 1'b1, 1'b1, 1'b1, 1'b0, 33'h0};
    tbl[1] = '{1'b1, 1'b0, 9'd5, 33'h0,           1'b1, 1'b1, 1'b0, 1'b0, 33'h0};
    tbl[2] = '{1'b0, 1'b0, 9'd0, 33'h0,           1'b1, 1'b1, 1'b0, 1'b0, 33'h0};
    tbl[3] = '{1'b0, 1'b0, 9'd0, 33'h0,           1'b1, 1'b1, 1'b0, 1'b0, 33'h0};
    tbl[4] = '{1'b0, 1'b0, 9'd0, 33'h0,           1'b1, 1'b1, 1'b0, 1'b1, 33'h1_2345_6789};
    tbl[5] = '{1'b0, 1'b0, 9'd0, 33'h0,           1'b1, 1'b1, 1'b0, 1'b0, 33'h0};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].valid, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      bus.rsp_ready = tbl[i].rsp_ready;
      #1;
      chk($sformatf("wr_rd[%0d].req_ready", i), 64'(bus.req_ready), 64'(tbl[i].exp_req_ready));
      chk($sformatf("wr_rd[%0d].ram_we", i),    64'(bus.ram_we),    64'(tbl[i].exp_ram_we));
      chk($sformatf("wr_rd[%0d].rsp_valid", i), 64'(bus.rsp_valid), 64'(tbl[i].exp_rsp_valid));
      if (tbl[i].exp_rsp_valid)
        chk($sformatf("wr_rd[%0d].rsp_rdata", i), 64'(bus.rsp_rdata), 64'(tbl[i].exp_rdata));
      if (tbl[i].valid) begin
        chk($sformatf("wr_rd[%0d].ram_addr", i), 64'(bus.ram_addr), 64'(tbl[i].addr));
        if (tbl[i].we)
          chk($sformatf("wr_rd[%0d].ram_din", i), 64'(bus.ram_din), 64'(tbl[i].wdata));
      end
      step();
    end
`endif

    // Backpressure: six reads with the consumer stalled.
    bus.rsp_ready = 1'b0;
    acc  = 0;
    base = n_rsp;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b0, ADDR_W'(32 + acc), '0);
      #1;
      if (bus.req_ready) acc++;
      step();
    end
    chk("bp_accepted", 64'(acc), 64'd4);
    drive(1'b1, 1'b0, ADDR_W'(32 + acc), '0);
    #1;
    chk("bp_req_ready_full", 64'(bus.req_ready), 64'd0);
    chk("bp_rsp_valid_full", 64'(bus.rsp_valid), 64'd1);

`ifndef TDP_RAM_CTRL_WACK_EN
    // Writes bypass credits while the response FIFO is full.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, ADDR_W'(100 + k), 33'h1_5555_0000 + DATA_W'(k));
      #1;
      chk("full_wr_req_ready", 64'(bus.req_ready), 64'd1);
      chk("full_wr_ram_we",    64'(bus.ram_we),    64'd1);
      step();
    end
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("full_wr_ram_we_idle", 64'(bus.ram_we), 64'd0);
    chk("full_wr_mem100", 64'(ram_mem[100]), 64'h1_5555_0000);
    chk("full_wr_mem101", 64'(ram_mem[101]), 64'h1_5555_0001);
    step();
`endif

    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40 && (n_rsp - base) < 6; c++) begin
      if (acc < 6) drive(1'b1, 1'b0, ADDR_W'(32 + acc), '0);
      else         drive(1'b0, 1'b0, '0, '0);
      #1;
      if (bus.req_valid && bus.req_ready) acc++;
      step();
    end
    chk("bp_total_accepted", 64'(acc), 64'd6);
    chk("bp_total_rsp", 64'(n_rsp - base), 64'd6);

`ifndef TDP_RAM_CTRL_WACK_EN
    base = n_rsp;
    drive(1'b1, 1'b0, 9'd100, '0);
    step();
    drive(1'b1, 1'b0, 9'd101, '0);
    step();
    drive(1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 10 && (n_rsp - base) < 2; c++) step();
    chk("readback_rsp_count", 64'(n_rsp - base), 64'd2);
`endif

    // Reset with two reads in flight and two in the FIFO.
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, ADDR_W'(40 + c), '0);
      #1;
      if (bus.req_ready) acc++;
      step();
    end
    chk("rst_setup_accepted", 64'(acc), 64'd4);
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("rst_setup_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 9'd50, 33'h0_DEAD_BEEF);
    #1;
    chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_mid_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_mid_ram_we",    64'(bus.ram_we),    64'd0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    exp_q.delete();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rst_no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
      chk("rst_req_ready",    64'(bus.req_ready), 64'd1);
      step();
    end
    chk("rst_mem_untouched", 64'(ram_mem[50]), 64'd50);

`ifdef TDP_RAM_CTRL_WACK_EN
    // Write, read, write: three ordered responses tagged 1, 0, 1.
    base = n_rsp;
    drive(1'b1, 1'b1, 9'd60, 33'h1_0F0F_0F0F);
    step();
    drive(1'b1, 1'b0, 9'd60, '0);
    step();
    drive(1'b1, 1'b1, 9'd61, 33'h0_1234_0000);
    step();
    drive(1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 10 && (n_rsp - base) < 3; c++) step();
    chk("wack_rsp_count", 64'(n_rsp - base), 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
